// File: rtl/add_pass_scheduler_pkg.sv
// Shared widths and FSM encoding for the two-pass add/sub scheduler.
package add_pass_scheduler_pkg;

    localparam int WORD_W = 32;
    localparam int HALF_W = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/add_pass_scheduler_if.sv
// Request/response bundle between the requesters (master) and the scheduler (slave).
interface add_pass_scheduler_if #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
);
    import add_pass_scheduler_pkg::*;

    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*WORD_W-1:0] req_a;
    logic [NREQ*WORD_W-1:0] req_b;
    logic [NREQ-1:0]        req_sub;
    logic                   resp_valid;
    logic                   resp_ready;
    logic [IDW-1:0]         resp_id;
    logic [WORD_W-1:0]      resp_sum;
    logic                   resp_cout;
    logic                   resp_ovf;

    modport master (
        output req_valid, req_a, req_b, req_sub, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_sum, resp_cout, resp_ovf
    );

    modport slave (
        input  req_valid, req_a, req_b, req_sub, resp_ready,
        output req_ready, resp_valid, resp_id, resp_sum, resp_cout, resp_ovf
    );

endinterface

// File: rtl/add_pass_arbiter.sv
// Combinational requester arbiter: round-robin from rr_ptr, or fixed lowest-index priority
// when ADD_PASS_SCHED_FIXED_PRIO_EN is defined (rr_ptr port is then absent).
module add_pass_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic [NREQ-1:0] req_valid,
`ifndef ADD_PASS_SCHED_FIXED_PRIO_EN
    input  logic [IDW-1:0]  rr_ptr,
`endif
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_id
);

`ifdef ADD_PASS_SCHED_FIXED_PRIO_EN
    // Scan from the lowest priority upward so the last hit (lowest index) wins.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
                grant_id = IDW'(i);
            end
        end
    end
`else
    // Offset k from rr_ptr; scanning k downward leaves the closest valid requester granted.
    always_comb begin
        int idx;
        grant    = '0;
        grant_id = '0;
        idx      = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (req_valid[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                grant_id   = IDW'(idx);
            end
        end
    end
`endif

endmodule

// File: rtl/sixteen_bit_adder.sv
// 16-bit ripple-carry adder with carry out and signed overflow (carry into MSB xor carry out).
module sixteen_bit_adder
    import add_pass_scheduler_pkg::*;
(
    input  logic [HALF_W-1:0] a,
    input  logic [HALF_W-1:0] b,
    input  logic              c_in,
    output logic [HALF_W-1:0] sum,
    output logic              c_out,
    output logic              ovf
);

    logic [HALF_W:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = c_in;
        for (int i = 0; i < HALF_W; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign c_out = c[HALF_W];
    assign ovf   = c[HALF_W] ^ c[HALF_W-1];

endmodule

// File: rtl/add_pass_scheduler.sv
// Shares one 16-bit adder between NREQ requesters; each 32-bit add/sub runs as a LO pass then a HI pass.
// Build option: ADD_PASS_SCHED_FIXED_PRIO_EN replaces round-robin with fixed lowest-index priority.
//   state  | meaning
//   S_IDLE | arbitrate; capture winner's operands and id
//   S_LO   | low half through the adder, keep sum[15:0] and carry c16
//   S_HI   | high half with c16 fed back, load response registers
//   S_DONE | response held until resp_ready
module add_pass_scheduler
    import add_pass_scheduler_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input logic                 clk,
    input logic                 reset,
    add_pass_scheduler_if.slave bus
);

    localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);
    localparam logic [IDW-1:0] ONE_ID  = IDW'(1);

    state_t              state;
    logic [NREQ-1:0]     grant;
    logic [IDW-1:0]      grant_id;
    logic [WORD_W-1:0]   sel_a;
    logic [WORD_W-1:0]   sel_b;
    logic                sel_sub;

    logic [WORD_W-1:0]   op_a;
    logic [WORD_W-1:0]   op_b;
    logic                op_sub;
    logic [IDW-1:0]      op_id;
    logic [HALF_W-1:0]   sum_lo;
    logic                c16;

    logic                hi_pass;
    logic [HALF_W-1:0]   add_a;
    logic [HALF_W-1:0]   add_b;
    logic                add_cin;
    logic [HALF_W-1:0]   add_sum;
    logic                add_cout;
    logic                add_ovf;

    logic                resp_valid;
    logic [IDW-1:0]      resp_id;
    logic [WORD_W-1:0]   resp_sum;
    logic                resp_cout;
    logic                resp_ovf;

`ifdef ADD_PASS_SCHED_FIXED_PRIO_EN
    add_pass_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req_valid (bus.req_valid),
        .grant     (grant),
        .grant_id  (grant_id)
    );
`else
    logic [IDW-1:0] rr_ptr;

    add_pass_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req_valid (bus.req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .grant_id  (grant_id)
    );
`endif

    always_comb begin
        sel_a   = bus.req_a[int'(grant_id)*WORD_W +: WORD_W];
        sel_b   = bus.req_b[int'(grant_id)*WORD_W +: WORD_W];
        sel_sub = bus.req_sub[grant_id];
    end

    // Grant is only offered while idle; held off during reset so nothing is accepted.
    assign bus.req_ready = (state == S_IDLE && !reset) ? grant : '0;

    // Subtraction is A + ~B + 1: invert B per half and inject the +1 as the LO carry-in.
    assign hi_pass = (state == S_HI);
    assign add_a   = hi_pass ? op_a[WORD_W-1:HALF_W] : op_a[HALF_W-1:0];
    assign add_b   = (hi_pass ? op_b[WORD_W-1:HALF_W] : op_b[HALF_W-1:0]) ^ {HALF_W{op_sub}};
    assign add_cin = hi_pass ? c16 : op_sub;

    sixteen_bit_adder u_adder (
        .a     (add_a),
        .b     (add_b),
        .c_in  (add_cin),
        .sum   (add_sum),
        .c_out (add_cout),
        .ovf   (add_ovf)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
`ifndef ADD_PASS_SCHED_FIXED_PRIO_EN
            rr_ptr     <= '0;
`endif
            op_a       <= '0;
            op_b       <= '0;
            op_sub     <= 1'b0;
            op_id      <= '0;
            sum_lo     <= '0;
            c16        <= 1'b0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_sum   <= '0;
            resp_cout  <= 1'b0;
            resp_ovf   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (|grant) begin
                        op_a   <= sel_a;
                        op_b   <= sel_b;
                        op_sub <= sel_sub;
                        op_id  <= grant_id;
`ifndef ADD_PASS_SCHED_FIXED_PRIO_EN
                        rr_ptr <= (grant_id == LAST_ID) ? '0 : grant_id + ONE_ID;
`endif
                        state  <= S_LO;
                    end
                end
                S_LO: begin
                    sum_lo <= add_sum;
                    c16    <= add_cout;
                    state  <= S_HI;
                end
                S_HI: begin
                    resp_sum   <= {add_sum, sum_lo};
                    resp_cout  <= add_cout;
                    resp_ovf   <= add_ovf;
                    resp_id    <= op_id;
                    resp_valid <= 1'b1;
                    state      <= S_DONE;
                end
                S_DONE: begin
                    if (bus.resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.resp_valid = resp_valid;
    assign bus.resp_id    = resp_id;
    assign bus.resp_sum   = resp_sum;
    assign bus.resp_cout  = resp_cout;
    assign bus.resp_ovf   = resp_ovf;

endmodule
